// File: rtl/csr_pkg.sv
// Shared CSR constants for the trap sequencer: addresses, write-mode encodings,
// and the sequencer state codes.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [11:0] CSR_CYCLE   = 12'hC00;
    localparam logic [11:0] CSR_INSTRET = 12'hC02;

    localparam logic [1:0] WD_WRITE = 2'b00;
    localparam logic [1:0] WD_SET   = 2'b01;
    localparam logic [1:0] WD_CLEAR = 2'b10;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SAVE_EPC   = 3'd1;
    localparam logic [2:0] ST_SAVE_CAUSE = 3'd2;
    localparam logic [2:0] ST_CLR_MIE    = 3'd3;
    localparam logic [2:0] ST_READ_VEC   = 3'd4;
    localparam logic [2:0] ST_READ_EPC   = 3'd5;
    localparam logic [2:0] ST_SET_MIE    = 3'd6;
    localparam logic [2:0] ST_REDIRECT   = 3'd7;

    function automatic logic [31:0] align_base(input logic [31:0] v);
        return v & ~32'h3;
    endfunction

endpackage

// File: rtl/csr_trap_sequencer.sv
// CSR access-port initiator: forwards pipeline CSR traffic while idle and
// sequences trap entry / MRET. Optional vectored mtvec: CSR_VECTORED_MODE_EN.
//
// state      | meaning
// IDLE       | forward pipe_* to CSR bus, wait for trap/mret
// SAVE_EPC   | write latched pc to mepc
// SAVE_CAUSE | write latched cause to mcause
// CLR_MIE    | clear mstatus.MIE
// READ_VEC   | read mtvec, latch handler target
// READ_EPC   | read mepc, latch return target
// SET_MIE    | set mstatus.MIE
// REDIRECT   | pulse redirect_valid with latched target
module csr_trap_sequencer
    import csr_pkg::*;
#(
    parameter logic [11:0] MSTATUS_ADDR = CSR_MSTATUS,
    parameter logic [11:0] MTVEC_ADDR   = CSR_MTVEC,
    parameter logic [11:0] MEPC_ADDR    = CSR_MEPC,
    parameter logic [11:0] MCAUSE_ADDR  = CSR_MCAUSE,
    parameter int          MIE_BIT      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    input  logic [11:0] pipe_addr,
    input  logic [31:0] pipe_wdata,
    input  logic        pipe_rd,
    input  logic        pipe_wr,
    input  logic [1:0]  pipe_wd_sel,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_rd,
    output logic        csr_wr,
    output logic [1:0]  csr_wd_sel,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [31:0] MIE_MASK = 32'h1 << MIE_BIT;

    logic [2:0]  state;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
    logic [31:0] target_q;
    logic [31:0] vec_target;

    always_comb begin
        vec_target = align_base(csr_rdata);
`ifdef CSR_VECTORED_MODE_EN
        // Vectored mode only offsets interrupts; exceptions still land on base.
        if (csr_rdata[1:0] == 2'b01 && cause_q[31])
            vec_target = vec_target + {25'd0, cause_q[4:0], 2'b00};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trap_req) begin
                        pc_q    <= trap_pc;
                        cause_q <= trap_cause;
                        state   <= ST_SAVE_EPC;
                    end else if (mret_req) begin
                        state <= ST_READ_EPC;
                    end
                end
                ST_SAVE_EPC:   state <= ST_SAVE_CAUSE;
                ST_SAVE_CAUSE: state <= ST_CLR_MIE;
                ST_CLR_MIE:    state <= ST_READ_VEC;
                ST_READ_VEC: begin
                    target_q <= vec_target;
                    state    <= ST_REDIRECT;
                end
                ST_READ_EPC: begin
                    target_q <= csr_rdata;
                    state    <= ST_SET_MIE;
                end
                ST_SET_MIE:    state <= ST_REDIRECT;
                default:       state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        csr_addr       = '0;
        csr_wdata      = '0;
        csr_rd         = 1'b0;
        csr_wr         = 1'b0;
        csr_wd_sel     = WD_WRITE;
        redirect_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                csr_addr   = pipe_addr;
                csr_wdata  = pipe_wdata;
                csr_rd     = pipe_rd;
                csr_wr     = pipe_wr;
                csr_wd_sel = pipe_wd_sel;
            end
            ST_SAVE_EPC: begin
                csr_addr  = MEPC_ADDR;
                csr_wdata = pc_q;
                csr_wr    = 1'b1;
            end
            ST_SAVE_CAUSE: begin
                csr_addr  = MCAUSE_ADDR;
                csr_wdata = cause_q;
                csr_wr    = 1'b1;
            end
            ST_CLR_MIE: begin
                csr_addr   = MSTATUS_ADDR;
                csr_wdata  = MIE_MASK;
                csr_wd_sel = WD_CLEAR;
                csr_wr     = 1'b1;
            end
            ST_READ_VEC: begin
                csr_addr = MTVEC_ADDR;
                csr_rd   = 1'b1;
            end
            ST_READ_EPC: begin
                csr_addr = MEPC_ADDR;
                csr_rd   = 1'b1;
            end
            ST_SET_MIE: begin
                csr_addr   = MSTATUS_ADDR;
                csr_wdata  = MIE_MASK;
                csr_wd_sel = WD_SET;
                csr_wr     = 1'b1;
            end
            default: redirect_valid = 1'b1;
        endcase
    end

    assign busy        = (state != ST_IDLE);
    assign redirect_pc = target_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer with a small behavioural CSR block.
// Honors CSR_VECTORED_MODE_EN for the vectored-target expectations.
module tb_csr_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic        mret_req = 1'b0;
    logic [11:0] pipe_addr = '0;
    logic [31:0] pipe_wdata = '0;
    logic        pipe_rd = 1'b0;
    logic        pipe_wr = 1'b0;
    logic [1:0]  pipe_wd_sel = '0;
    logic [31:0] csr_rdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_rd;
    logic        csr_wr;
    logic [1:0]  csr_wd_sel;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_mstatus = '0;
    logic [31:0] m_mtvec   = '0;
    logic [31:0] m_mepc    = '0;
    logic [31:0] m_mcause  = '0;
    int          pulses    = 0;

    always #5 clk = ~clk;

    csr_trap_sequencer dut (
        .clk(clk), .rst(rst),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_req(mret_req),
        .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_rd(pipe_rd),
        .pipe_wr(pipe_wr), .pipe_wd_sel(pipe_wd_sel),
        .csr_rdata(csr_rdata),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rd(csr_rd),
        .csr_wr(csr_wr), .csr_wd_sel(csr_wd_sel),
        .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Behavioural CSR block: combinational read, write/set/clear at the edge.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = '0;
        endcase
    end

    function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] sel);
        case (sel)
            2'b01:   return old | d;
            2'b10:   return old & ~d;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (csr_wr) begin
            case (csr_addr)
                12'h300: m_mstatus <= apply(m_mstatus, csr_wdata, csr_wd_sel);
                12'h305: m_mtvec   <= apply(m_mtvec, csr_wdata, csr_wd_sel);
                12'h341: m_mepc    <= apply(m_mepc, csr_wdata, csr_wd_sel);
                12'h342: m_mcause  <= apply(m_mcause, csr_wdata, csr_wd_sel);
                default: ;
            endcase
        end
        if (rst && redirect_valid) pulses <= pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_clear();
        pipe_addr = '0; pipe_wdata = '0; pipe_rd = 1'b0; pipe_wr = 1'b0; pipe_wd_sel = '0;
    endtask

    task automatic pipe_write(input logic [11:0] a, input logic [31:0] d);
        pipe_addr = a; pipe_wdata = d; pipe_wr = 1'b1; pipe_wd_sel = 2'b00; pipe_rd = 1'b0;
        tick();
        pipe_clear();
    endtask

    task automatic test_reset();
        pipe_clear();
        #2;
        n_cmp++;
        if ({busy, redirect_valid, csr_wr, csr_rd, csr_addr, csr_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b rv=%b wr=%b rd=%b addr=%h wdata=%h required all 0",
                     busy, redirect_valid, csr_wr, csr_rd, csr_addr, csr_wdata);
        end
        n_cmp++;
        if (redirect_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_redirect_pc: got %h required 0", redirect_pc);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_idle_passthrough();
        pipe_addr = 12'h305; pipe_wr = 1'b1; pipe_wdata = 32'h100; pipe_wd_sel = 2'b00;
        #1;
        n_cmp++;
        if ({csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel, busy} !==
            {12'h305, 32'h100, 1'b1, 1'b0, 2'b00, 1'b0}) begin
            n_err++;
            $display("FAIL idle_fwd_write: got addr=%h wdata=%h wr=%b rd=%b sel=%b busy=%b required 305/100/1/0/00/0",
                     csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel, busy);
        end
        pipe_addr = 12'h342; pipe_wr = 1'b0; pipe_rd = 1'b1; pipe_wd_sel = 2'b10;
        #1;
        n_cmp++;
        if ({csr_addr, csr_wr, csr_rd, csr_wd_sel} !== {12'h342, 1'b0, 1'b1, 2'b10}) begin
            n_err++;
            $display("FAIL idle_fwd_read: got addr=%h wr=%b rd=%b sel=%b required 342/0/1/10",
                     csr_addr, csr_wr, csr_rd, csr_wd_sel);
        end
        pipe_clear();
    endtask

    task automatic test_trap_entry();
        int busy_cycles;
        pipe_write(12'h305, 32'h0000_0200);
        pipe_write(12'h300, 32'h0000_0008);
        trap_req = 1'b1; trap_pc = 32'h84; trap_cause = 32'h2;
        tick();
        trap_req = 1'b0; trap_pc = '0; trap_cause = '0;
        busy_cycles = 0;
        n_cmp++;
        if ({busy, csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel} !==
            {1'b1, 12'h341, 32'h84, 1'b1, 1'b0, 2'b00}) begin
            n_err++;
            $display("FAIL trap_save_epc: got busy=%b addr=%h wdata=%h wr=%b rd=%b sel=%b required 1/341/84/1/0/00",
                     busy, csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel);
        end
        if (busy) busy_cycles++;
        tick();
        n_cmp++;
        if ({csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel} !== {12'h342, 32'h2, 1'b1, 1'b0, 2'b00}) begin
            n_err++;
            $display("FAIL trap_save_cause: got addr=%h wdata=%h wr=%b rd=%b sel=%b required 342/2/1/0/00",
                     csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel);
        end
        if (busy) busy_cycles++;
        tick();
        n_cmp++;
        if ({csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel} !== {12'h300, 32'h8, 1'b1, 1'b0, 2'b10}) begin
            n_err++;
            $display("FAIL trap_clr_mie: got addr=%h wdata=%h wr=%b rd=%b sel=%b required 300/8/1/0/10",
                     csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel);
        end
        if (busy) busy_cycles++;
        tick();
        n_cmp++;
        if ({csr_addr, csr_wr, csr_rd, redirect_valid} !== {12'h305, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL trap_read_vec: got addr=%h wr=%b rd=%b rv=%b required 305/0/1/0",
                     csr_addr, csr_wr, csr_rd, redirect_valid);
        end
        if (busy) busy_cycles++;
        tick();
        n_cmp++;
        if ({redirect_valid, redirect_pc, csr_wr, csr_rd} !== {1'b1, 32'h200, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL trap_redirect: got rv=%b pc=%h wr=%b rd=%b required 1/200/0/0",
                     redirect_valid, redirect_pc, csr_wr, csr_rd);
        end
        if (busy) busy_cycles++;
        tick();
        n_cmp++;
        if ({busy, redirect_valid, redirect_pc} !== {1'b0, 1'b0, 32'h200} || busy_cycles != 5) begin
            n_err++;
            $display("FAIL trap_end: got busy=%b rv=%b pc=%h busy_cycles=%0d required 0/0/200/5",
                     busy, redirect_valid, redirect_pc, busy_cycles);
        end
        n_cmp++;
        if ({m_mepc, m_mcause, m_mstatus} !== {32'h84, 32'h2, 32'h0}) begin
            n_err++;
            $display("FAIL trap_csr_state: got mepc=%h mcause=%h mstatus=%h required 84/2/0",
                     m_mepc, m_mcause, m_mstatus);
        end
    endtask

    task automatic test_mret(input logic [31:0] epc, input string tag);
        int busy_cycles;
        pipe_write(12'h341, epc);
        pipe_write(12'h300, 32'h0);
        mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        busy_cycles = busy ? 1 : 0;
        n_cmp++;
        if ({csr_addr, csr_rd, csr_wr} !== {12'h341, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL %s_read_epc: got addr=%h rd=%b wr=%b required 341/1/0", tag, csr_addr, csr_rd, csr_wr);
        end
        tick();
        if (busy) busy_cycles++;
        n_cmp++;
        if ({csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel} !== {12'h300, 32'h8, 1'b1, 1'b0, 2'b01}) begin
            n_err++;
            $display("FAIL %s_set_mie: got addr=%h wdata=%h wr=%b rd=%b sel=%b required 300/8/1/0/01",
                     tag, csr_addr, csr_wdata, csr_wr, csr_rd, csr_wd_sel);
        end
        tick();
        if (busy) busy_cycles++;
        n_cmp++;
        if ({redirect_valid, redirect_pc} !== {1'b1, epc}) begin
            n_err++;
            $display("FAIL %s_redirect: got rv=%b pc=%h required 1/%h", tag, redirect_valid, redirect_pc, epc);
        end
        tick();
        if (busy) busy_cycles++;
        n_cmp++;
        if (busy_cycles != 3 || redirect_valid !== 1'b0 || m_mstatus !== 32'h8) begin
            n_err++;
            $display("FAIL %s_end: got busy_cycles=%0d rv=%b mstatus=%h required 3/0/8",
                     tag, busy_cycles, redirect_valid, m_mstatus);
        end
    endtask

    task automatic test_simultaneous();
        int p0;
        pipe_write(12'h305, 32'h0000_0200);
        p0 = pulses;
        trap_req = 1'b1; mret_req = 1'b1; trap_pc = 32'h40; trap_cause = 32'hB;
        tick();
        trap_req = 1'b0; mret_req = 1'b0;
        pipe_addr = 12'h342; pipe_wdata = 32'hDEAD; pipe_wr = 1'b1; pipe_wd_sel = 2'b00;
        n_cmp++;
        if ({csr_addr, csr_wdata} !== {12'h341, 32'h40}) begin
            n_err++;
            $display("FAIL simul_first_access: got addr=%h wdata=%h required 341/40", csr_addr, csr_wdata);
        end
        repeat (4) tick();
        pipe_clear();
        tick();
        tick();
        n_cmp++;
        if ({m_mepc, m_mcause, m_mtvec} !== {32'h40, 32'hB, 32'h200} || pulses - p0 != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL simul_result: got mepc=%h mcause=%h mtvec=%h pulses=%0d busy=%b required 40/b/200/1/0",
                     m_mepc, m_mcause, m_mtvec, pulses - p0, busy);
        end
    endtask

    task automatic test_reset_mid_trap();
        int p0;
        pipe_write(12'h300, 32'h8);
        p0 = pulses;
        trap_req = 1'b1; trap_pc = 32'h84; trap_cause = 32'h2;
        tick();
        trap_req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({csr_addr, csr_wd_sel} !== {12'h300, 2'b10}) begin
            n_err++;
            $display("FAIL rst_mid_reach_clr: got addr=%h sel=%b required 300/10", csr_addr, csr_wd_sel);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, redirect_valid, csr_wr, csr_rd, csr_addr, csr_wdata, csr_wd_sel, redirect_pc} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got busy=%b rv=%b wr=%b rd=%b addr=%h wdata=%h pc=%h required all 0",
                     busy, redirect_valid, csr_wr, csr_rd, csr_addr, csr_wdata, redirect_pc);
        end
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({m_mepc, m_mcause, m_mstatus} !== {32'h84, 32'h2, 32'h8} || pulses != p0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_csr_state: got mepc=%h mcause=%h mstatus=%h pulses=%0d busy=%b required 84/2/8/0/0",
                     m_mepc, m_mcause, m_mstatus, pulses - p0, busy);
        end
    endtask

    task automatic test_vectored(input logic [31:0] cause, input logic [31:0] exp_pc, input string tag);
        pipe_write(12'h305, 32'h0000_0201);
        trap_req = 1'b1; trap_pc = 32'h10; trap_cause = cause;
        tick();
        trap_req = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if ({redirect_valid, redirect_pc} !== {1'b1, exp_pc}) begin
            n_err++;
            $display("FAIL %s: got rv=%b pc=%h required 1/%h", tag, redirect_valid, redirect_pc, exp_pc);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_passthrough();
        test_trap_entry();
        test_mret(32'h1000, "mret");
        test_mret(32'h1003, "mret_lowbits");
        test_simultaneous();
        test_reset_mid_trap();
`ifdef CSR_VECTORED_MODE_EN
        test_vectored(32'h8000_0007, 32'h21C, "vec_irq");
`else
        test_vectored(32'h8000_0007, 32'h200, "direct_irq");
`endif
        test_vectored(32'h5, 32'h200, "vec_exception");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
